// File: rtl/tag_retire_queue.sv
// In-order tag retire ring: tags from the freelist are pushed in program order, marked done
// by the completion ports and handed back to the freelist collect ports strictly from the head.
module tag_retire_queue #(
    parameter int DEPTH = 16,
    parameter int TAG   = 4,
    parameter int PUSH  = 4,
    parameter int CMP   = 4,
    parameter int RET   = 4,
    parameter int IDX   = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset_,
    input  logic                      flush_,
    input  logic [PUSH-1:0]           push_,
    input  logic [PUSH-1:0][TAG-1:0]  push_tag,
    output logic [PUSH-1:0][IDX-1:0]  push_idx,
    input  logic [CMP-1:0]            cmp_,
    input  logic [CMP-1:0][IDX-1:0]   cmp_idx,
    output logic [RET-1:0]            ret_,
    output logic [RET-1:0][TAG-1:0]   ret_tag,
    output logic [IDX:0]              count,
    output logic                      full,
    output logic                      empty
);

    localparam logic [IDX:0] FULL_AT = (IDX+1)'(DEPTH - PUSH);
    localparam logic [IDX:0] ONE     = (IDX+1)'(1);

    logic [DEPTH-1:0]          valid_q;
    logic [DEPTH-1:0]          done_q;
    logic [DEPTH-1:0][TAG-1:0] tag_q;
    logic [IDX-1:0]            head_q;
    logic [IDX-1:0]            tail_q;
    logic [IDX:0]              count_q;

    logic [IDX:0]              push_ofs;
    logic [IDX:0]              npush;
    logic [IDX:0]              nret;
    logic                      do_push;
    logic                      ret_run;
    logic [IDX-1:0]            ret_at;

    // Push contract: an asserted push_ lane is accepted only while full is low; upstream gates
    // push_ with full, and any push presented while full (or during flush) is dropped whole.
    assign full    = count_q > FULL_AT;
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign do_push = flush_ && !full;
    assign npush   = do_push ? push_ofs : '0;

    // Asserted lanes pack onto consecutive entries starting at tail.
    always_comb begin
        push_ofs = '0;
        push_idx = '0;
        for (int i = 0; i < PUSH; i++) begin
            push_idx[i] = tail_q + push_ofs[IDX-1:0];
            if (!push_[i]) begin
                push_ofs = push_ofs + ONE;
            end
        end
    end

    // Retire lanes form a prefix of valid+done entries from head; flush suppresses them.
    always_comb begin
        ret_    = '1;
        ret_tag = '0;
        nret    = '0;
        ret_run = flush_;
        ret_at  = '0;
        for (int k = 0; k < RET; k++) begin
            ret_at  = head_q + IDX'(k);
            ret_run = ret_run && valid_q[ret_at] && done_q[ret_at];
            if (ret_run) begin
                ret_[k]    = 1'b0;
                ret_tag[k] = tag_q[ret_at];
                nret       = nret + ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            valid_q <= '0;
            done_q  <= '0;
            tag_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (!flush_) begin
            valid_q <= '0;
            done_q  <= '0;
            tag_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            for (int c = 0; c < CMP; c++) begin
                if (!cmp_[c] && valid_q[cmp_idx[c]]) begin
                    done_q[cmp_idx[c]] <= 1'b1;
                end
            end
            // Later assignments win: retire clears override a completion on the same entry.
            for (int k = 0; k < RET; k++) begin
                if ((IDX+1)'(k) < nret) begin
                    valid_q[head_q + IDX'(k)] <= 1'b0;
                    done_q[head_q + IDX'(k)]  <= 1'b0;
                end
            end
            if (do_push) begin
                for (int i = 0; i < PUSH; i++) begin
                    if (!push_[i]) begin
                        valid_q[push_idx[i]] <= 1'b1;
                        done_q[push_idx[i]]  <= 1'b0;
                        tag_q[push_idx[i]]   <= push_tag[i];
                    end
                end
            end
            head_q  <= head_q + nret[IDX-1:0];
            tail_q  <= tail_q + npush[IDX-1:0];
            count_q <= count_q + npush - nret;
        end
    end

endmodule

// File: doc/tag_retire_queue.md
Name: tag_retire_queue

Overview:
In-order ring buffer that sits downstream of freelist and closes the tag loop. Allocated tags from the freelist (rd/v) are pushed in program order and marked done by completion ports. They are retired strictly in order from the head. Retired tags are driven directly onto the freelist collect ports (we_/wd), so ret_/ret_tag connect 1:1 to freelist we_/wd in scalar (BIT_VEC=Disable) mode.

Parameters:
DEPTH, 16, number of entries; must be a power of 2
TAG, 4, tag width; equals $clog2(freelist DEPTH)
PUSH, 4, push lanes per cycle; equals freelist READ
CMP, 4, completion lanes per cycle
RET, 4, retire lanes per cycle; equals freelist WRITE
IDX, $clog2(DEPTH), entry index width (derived)

Ports:
clk  in  1  clock
reset_  in  1  asynchronous active-low reset
flush_  in  1  active-low synchronous clear of all entries
push_  in  PUSH  active-low push request per lane
push_tag  in  PUSH x TAG  tag to enqueue per lane
push_idx  out  PUSH x IDX  entry index assigned to each lane (combinational)
cmp_  in  CMP  active-low completion per lane
cmp_idx  in  CMP x IDX  entry index being completed
ret_  out  RET  active-low retire valid per lane; feeds freelist we_
ret_tag  out  RET x TAG  retired tag per lane; feeds freelist wd
count  out  IDX+1  number of valid entries
full  out  1  asserted when (DEPTH - count) < PUSH
empty  out  1  asserted when count == 0

Behaviour:
- State: head, tail (IDX bits, natural wrap), count (IDX+1 bits), per-entry valid, done and tag registers.
- Reset (async, reset_ low): valid/done=0, head=tail=0, count=0; ret_ all 1, ret_tag 0, full 0, empty 1.
- Push:
  - Lanes may be sparse. Asserted lanes take consecutive entries in ascending lane order.
  - push_idx[i] = tail + (number of asserted lanes below i), mod DEPTH. This is valid for asserted lanes; don't-care otherwise.
  - At the clock edge each entry gets valid=1, done=0, tag=push_tag. tail advances by npush.
  - If full=1, all pushes in that cycle are discarded with no state change. Upstream must gate pushes with full.
- Completion:
  - At the edge, done[cmp_idx]=1 if that entry is valid. Completion of an invalid entry is ignored.
  - Duplicate cmp_idx across lanes is legal (OR).
  - A completion targeting an entry being pushed in the same cycle is ignored; the push wins with done=0.
- Retire (combinational from registers only):
  - Lane k asserts ret_[k]=0 iff entries head..head+k are all valid and done.
  - ret_tag[k] = tag[head+k]. Lanes above the first non-retirable entry are 1, with ret_tag 0.
  - At the edge the retired entries are cleared and head advances by nret.
  - A completion registered at edge t is retirable in the cycle after t (one-cycle latency).
- Simultaneous events: count_next = count + npush - nret.
  - Push and retire never address the same entry, since count+npush <= DEPTH.
  - full/empty are computed from the registered count.
- Flush (flush_ low, no reset):
  - ret_ is forced all 1 in that cycle.
  - Pushes and completions in that cycle are discarded.
  - At the edge the state is cleared exactly as at reset.
  - The freelist is flushed concurrently, so in-flight tags are not returned.
- Wrap-around: indices wrap modulo DEPTH for pointers, push_idx and retire lanes. An entry at index DEPTH-1 followed by index 0 retires in the same cycle.
- An asynchronous reset mid-operation discards all state immediately; outputs take their reset values without waiting for a clock edge.

Test Plan:
- Reset, then push lanes 0-3 with tags 3,7,9,12 -> push_idx 0,1,2,3; next cycle count=4, empty=0, full=0, ret_=4'b1111.
- Complete idx 1 -> no retire. Then complete idx 0 -> the next cycle ret_=4'b1100 with ret_tag[0]=3, ret_tag[1]=7; the following cycle count=2.
- Sparse push on lanes 0 and 2 with tail=5 -> push_idx[0]=5, push_idx[2]=6; entries 5,6 valid; count rises by 2.
- Fill to count=13 -> full=1. Assert push_ on all lanes -> count stays 13 and tail is unchanged.
- Head=14 with entries 14,15,0,1 all done -> ret_=4'b0000 in one cycle, tags in order, head becomes 2.
- With count=6, assert flush_ together with push and completion -> ret_ all 1 that cycle; next cycle count=0, empty=1, head=tail=0.
